uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter that drains the TX FIFO. It is the read side of the FIFO that the APB write path fills. It pops one word whenever the FIFO is non-empty and transmission is enabled, then serialises it LSB-first as start, data, optional parity and stop bits. Bit timing comes from an external oversampling tick generated by the baud generator.

Parameters:
WIDTH_DATA, 8, data bits per frame; must match the FIFO word width.
OVERSAMPLE, 16, tick pulses per bit period; minimum 2.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
tick  input  1  oversample strobe, one clk cycle wide, OVERSAMPLE per bit
tx_en  input  1  enable from APB control register
fifo_mpty  input  1  FIFO empty flag
fifo_rdata  input  WIDTH_DATA  FIFO head word, combinationally valid while fifo_mpty=0
fifo_rd  output  1  pop strobe to FIFO
tx  output  1  serial line, idle high
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of stop bit

Behaviour:
- Reset and clock: reset rst, asynchronous, active-high; clock clk. Reset mid-frame aborts immediately.
- Reset values: state IDLE, tx=1, busy=0, tx_done=0, fifo_rd=0, all counters 0, shift register 0.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - fifo_rd = (state==IDLE) & tx_en & ~fifo_mpty. This is combinational, so the pulse is exactly one cycle.
  - In the same cycle, fifo_rdata is latched into the shift register, the tick counter is cleared, and the next state is START.
- tick and bit counters:
  - tick_cnt counts tick pulses 0..OVERSAMPLE-1.
  - A bit ends on the tick where tick_cnt==OVERSAMPLE-1; tick_cnt then wraps to 0.
  - Ticks arriving in IDLE are ignored.
- START: tx=0 for one bit period, then DATA with bit_cnt=0.
- DATA:
  - tx = shift register bit 0.
  - At each bit end, shift right and increment bit_cnt.
  - After bit_cnt==WIDTH_DATA-1, go to PARITY if the macro is defined, otherwise STOP.
- STOP:
  - tx=1 for one bit period.
  - At bit end, pulse tx_done for one cycle and return to IDLE.
  - IDLE may pop the next word on the following cycle, giving a one-clk inter-frame gap.
- tx is registered: it is driven from state and shift register through a flop, one-cycle delay from state entry. It is 1 in IDLE and STOP.
- busy=1 in every state except IDLE.
- tx_en deasserted mid-frame: the current frame completes normally and no new pop occurs.
- tx_en or fifo_mpty changes while not in IDLE: no effect.
- FIFO empty after a pop: stay in IDLE with tx=1 and fifo_rd=0.
- A tick coincident with the pop cycle is not counted.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - Parity is computed as XOR of the latched word at pop time, giving even parity.
  - State PARITY sits between DATA and STOP and transmits the parity bit for one bit period.
  - Frame length is WIDTH_DATA+3 bits.
- Undefined:
  - No PARITY state and no parity register.
  - Frame length is WIDTH_DATA+2 bits.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_tx_state_e {IDLE, START, DATA, PARITY, STOP}
  - localparam default OVERSAMPLE=16
  - localparam UART_IDLE_LEVEL=1'b1
- Single module, no sub-module. The baud tick generator and the FIFO are separate existing blocks.

Test Plan:
- Reset mid-DATA of 0x3C -> tx=1, busy=0, fifo_rd=0 immediately. After release with FIFO empty, tx stays 1 for 500 cycles.
- Single word 0xA5, tick every clk, OVERSAMPLE=16, tx_en=1 -> fifo_rd pulses exactly once. tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles. tx_done pulses once, at cycle 160 after the pop.
- Two words 0x01, 0xFF queued -> two pops, two frames separated by exactly one idle clk. Bits are 0,1,0000000,1 then 0,11111111,1.
- tx_en dropped during DATA of 0x55, FIFO holding 2 more words -> frame 0x55 completes, no further fifo_rd, busy=0. Raising tx_en resumes with the next word.
- tick once every 4 clks, word 0x80 -> each bit lasts 64 clks, MSB bit high in the last data slot.
- With UART_TX_PARITY_EN: 0xA5 gives parity bit 0 and 0x07 gives parity bit 1, each followed by stop=1. Frame is 11 bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, default
// oversampling ratio and the idle level of the serial line.
package uart_pkg;

  // Transmit FSM states. PARITY is only visited when UART_TX_PARITY_EN is
  // defined; the encoding is kept identical in both builds.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  // Tick pulses per bit period unless the instance overrides it.
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Level held on the serial line while no frame is being sent.
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// UART transmitter: read side of the TX FIFO. Pops a word whenever the FIFO
// is non-empty and tx_en is set, then shifts it out LSB-first as
// start / data / [parity] / stop, one bit per OVERSAMPLE tick pulses.
// Optional even parity bit is built in when UART_TX_PARITY_EN is defined.
//
// Handshake with the FIFO: fifo_rd is a single-cycle pop strobe, asserted
// combinationally while the FSM is in IDLE, tx_en is high and fifo_mpty is
// low; fifo_rdata is captured in that same cycle, so the FIFO must present
// the head word combinationally whenever it is not empty.
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH_DATA = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  tx_en,
  input  logic                  fifo_mpty,
  input  logic [WIDTH_DATA-1:0] fifo_rdata,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  // Counter widths; OVERSAMPLE and WIDTH_DATA are at least 2, so a 1-bit
  // floor keeps the vectors legal for the smallest configurations.
  localparam int TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (WIDTH_DATA > 2) ? $clog2(WIDTH_DATA) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH_DATA - 1);

  uart_tx_state_e         state;
  logic [TICK_W-1:0]      tick_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [WIDTH_DATA-1:0]  shift_q;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
`endif

  logic pop;
  logic bit_end;

  // A pop can only start from IDLE, so tx_en / fifo_mpty changes during a
  // frame are ignored and the strobe can never be longer than one cycle.
  assign pop     = (state == IDLE) & tx_en & ~fifo_mpty;
  assign fifo_rd = pop;

  // Current bit period finishes on the tick that takes tick_cnt past its
  // last value. Ticks in IDLE (including the pop cycle) never count.
  assign bit_end = (state != IDLE) & tick & (tick_cnt == TICK_LAST);

  // busy comes straight from the state register, so it drops in the same
  // cycle the FSM returns to IDLE and clears asynchronously on reset.
  assign busy = (state != IDLE);

  // Oversample tick counter: cleared on pop, wraps at the end of each bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (pop) begin
      tick_cnt <= '0;
    end else if ((state != IDLE) && tick) begin
      if (bit_end) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // Frame sequencer: state, shift register, bit counter, parity and the
  // end-of-frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shift_q  <= fifo_rdata;
            bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
            // XOR of the data bits makes the total count of ones even.
            parity_q <= ^fifo_rdata;
`endif
            state    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            tx_done <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Serial line register: follows the state one cycle late so the line is
  // glitch-free; idle and stop both drive the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx <= UART_IDLE_LEVEL;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_q[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  tx <= parity_q;
`endif
        default: tx <= UART_IDLE_LEVEL;
      endcase
    end
  end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx. Models the TX FIFO and the baud tick source,
// records the serial line cycle by cycle after each pop and checks it
// against a frame model built from the words queued in the scoreboard.
// Build with UART_TX_PARITY_EN defined to exercise the parity frames.
module tb_uart_tx;

  localparam int P    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB   = 11;
  localparam int PAR  = 1;
`else
  localparam int NB   = 10;
  localparam int PAR  = 0;
`endif
  localparam int WMAX = 2048;

  // Clock / reset and DUT connections
  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       tx_en;
  logic       fifo_mpty;
  logic [7:0] fifo_rdata;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       tx_done;

  always #5 clk = ~clk;

  uart_tx #(.WIDTH_DATA(8), .OVERSAMPLE(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .tx_en      (tx_en),
    .fifo_mpty  (fifo_mpty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  // Scoreboard and FIFO model
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         tick_div = 1;
  int         div_cnt = 0;
  bit         pop_req = 1'b0;

  // Capture buffers (index 0 = pop cycle) and model outputs
  bit          cap_tx[WMAX];
  bit          cap_tick[WMAX];
  bit          cap_done[WMAX];
  bit          cap_rd[WMAX];
  bit          cap_busy[WMAX];
  int          cap_n;
  bit          exp_tx[WMAX];
  bit          exp_done[WMAX];
  int          pops[$];
  logic [15:0] dec_q[$];
  int          tx_mis, done_mis, done_cnt, done_idx;

  // Pop request is taken from the settled strobe in the middle of the cycle
  always @(negedge clk) pop_req = fifo_rd;

  // FIFO head update and tick generation, just after each rising edge
  always @(posedge clk) begin
    logic [7:0] dropped;
    #1;
    if (pop_req && fifo_q.size() > 0) dropped = fifo_q.pop_front();
    if (tick_div > 0) begin
      if (div_cnt >= tick_div) div_cnt = 0;
      tick    = (div_cnt == 0);
      div_cnt = div_cnt + 1;
    end else begin
      tick = 1'b0;
    end
    fifo_mpty  = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  // Driver: queue a word in the FIFO and its expectation in the scoreboard
  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Wait (bounded) for a pop, then record ncyc cycles starting at it
  task automatic capture(input int ncyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fifo_rd) begin
        ok = 1'b1;
        break;
      end
    end
    cap_n = 0;
    if (!ok) return;
    cap_n = ncyc;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      cap_tx[c]   = tx;
      cap_tick[c] = tick;
      cap_done[c] = tx_done;
      cap_rd[c]   = fifo_rd;
      cap_busy[c] = busy;
    end
  endtask

  // Frame model: bit k of a frame occupies the line while the number of
  // ticks counted since the pop (ticks in cycles p+1 .. c-2) lies in
  // [k*P, (k+1)*P). The k-th pop in the window carries exp_q[k].
  // Also decodes the observed line at the middle of each bit.
  task automatic analyze();
    logic [15:0] fb, dec;
    bit          seen[16];
    int          p, cnt, nxt, idx;
    logic [7:0]  w;
    pops.delete();
    dec_q.delete();
    for (int c = 0; c < cap_n; c++) begin
      exp_tx[c]   = 1'b1;
      exp_done[c] = 1'b0;
      if (cap_rd[c]) pops.push_back(c);
    end
    for (int j = 0; j < pops.size(); j++) begin
      p  = pops[j];
      w  = (j < exp_q.size()) ? exp_q[j] : 8'h00;
      fb = '0;
      fb[8:1] = w;
`ifdef UART_TX_PARITY_EN
      fb[9] = ^w;
`endif
      fb[NB-1] = 1'b1;
      dec = '0;
      for (int k = 0; k < 16; k++) seen[k] = 1'b0;
      cnt = 0;
      for (int c = p + 2; c < cap_n; c++) begin
        idx = cnt / P;
        exp_tx[c] = (idx < NB) ? fb[idx] : 1'b1;
        if (idx < NB && !seen[idx] && cnt == idx * P + P / 2) begin
          dec[idx]  = cap_tx[c];
          seen[idx] = 1'b1;
        end
        nxt = cnt + int'(cap_tick[c-1]);
        if (cap_tick[c-1] && nxt == NB * P) exp_done[c] = 1'b1;
        cnt = nxt;
      end
      dec_q.push_back(dec);
    end
    tx_mis = 0; done_mis = 0; done_cnt = 0; done_idx = -1;
    for (int c = 1; c < cap_n; c++) begin
      if (cap_tx[c] != exp_tx[c]) tx_mis++;
      if (cap_done[c] != exp_done[c]) done_mis++;
      if (cap_done[c]) begin
        done_cnt++;
        if (done_idx < 0) done_idx = c;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd: got %b expected 0", fifo_rd); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] e;
    @(posedge clk); #1;
    tx_en = 1'b1;
    push_word(8'hA5);
    capture(NB * P + 6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_pop_timeout: got no pop expected one"); end
    analyze();
    checks++; if (pops.size() != 1) begin errors++; $display("FAIL single_pop_count: got %0d expected 1", pops.size()); end
    checks++; if (tx_mis != 0) begin errors++; $display("FAIL single_tx_wave: got %0d bad cycles expected 0", tx_mis); end
    e = exp_q.pop_front();
    checks++; if (dec_q.size() != 1 || dec_q[0][8:1] !== e) begin errors++; $display("FAIL single_data: got %0h expected %0h", (dec_q.size() > 0) ? dec_q[0][8:1] : 8'hxx, e); end
`ifdef UART_TX_PARITY_EN
    checks++; if (dec_q.size() != 1 || dec_q[0][10:0] !== 11'b10101001010) begin errors++; $display("FAIL single_bits: got %b expected 10101001010", (dec_q.size() > 0) ? dec_q[0][10:0] : 11'bx); end
`else
    checks++; if (dec_q.size() != 1 || dec_q[0][9:0] !== 10'b1101001010) begin errors++; $display("FAIL single_bits: got %b expected 1101001010", (dec_q.size() > 0) ? dec_q[0][9:0] : 10'bx); end
`endif
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt); end
    // tx_done is registered on the NB*P-th rising edge after the pop edge
    checks++; if (done_idx != NB * P + 1) begin errors++; $display("FAIL single_done_cycle: got %0d expected %0d", done_idx, NB * P + 1); end
    checks++; if (cap_busy[1] !== 1'b1) begin errors++; $display("FAIL single_busy_start: got %b expected 1", cap_busy[1]); end
    checks++; if (cap_busy[NB * P + 1] !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", cap_busy[NB * P + 1]); end
    checks++; if (cap_tx[NB * P + 5] !== 1'b1) begin errors++; $display("FAIL single_idle_tx: got %b expected 1", cap_tx[NB * P + 5]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] e;
    @(posedge clk); #1;
    push_word(8'h01);
    push_word(8'hFF);
    capture(2 * (NB * P + 1) + 6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_pop_timeout: got no pop expected one"); end
    analyze();
    checks++; if (pops.size() != 2) begin errors++; $display("FAIL b2b_pop_count: got %0d expected 2", pops.size()); end
    checks++; if (pops.size() != 2 || pops[1] != NB * P + 1) begin errors++; $display("FAIL b2b_gap: got second pop at %0d expected %0d", (pops.size() > 1) ? pops[1] : -1, NB * P + 1); end
    checks++; if (tx_mis != 0) begin errors++; $display("FAIL b2b_tx_wave: got %0d bad cycles expected 0", tx_mis); end
    checks++; if (done_cnt != 2 || done_mis != 0) begin errors++; $display("FAIL b2b_done: got %0d pulses %0d misplaced expected 2 and 0", done_cnt, done_mis); end
    checks++; if (cap_tx[NB * P + 2] !== 1'b1 || cap_tx[NB * P + 3] !== 1'b0) begin errors++; $display("FAIL b2b_idle_clk: got %b%b expected 10", cap_tx[NB * P + 2], cap_tx[NB * P + 3]); end
    for (int j = 0; j < 2; j++) begin
      e = exp_q.pop_front();
      checks++; if (dec_q.size() <= j || dec_q[j][8:1] !== e || dec_q[j][NB-1] !== 1'b1) begin errors++; $display("FAIL b2b_frame%0d: got %0h expected %0h with stop 1", j, (dec_q.size() > j) ? dec_q[j][8:1] : 8'hxx, e); end
    end
  endtask

  task automatic test_txen_drop();
    bit ok;
    logic [7:0] e;
    @(posedge clk); #1;
    push_word(8'h55);
    push_word(8'hAA);
    push_word(8'h33);
    fork
      capture(NB * P + 40, ok);
      begin
        repeat (40) @(posedge clk);
        #1 tx_en = 1'b0;
      end
    join
    checks++; if (!ok) begin errors++; $display("FAIL txen_pop_timeout: got no pop expected one"); end
    analyze();
    checks++; if (pops.size() != 1) begin errors++; $display("FAIL txen_pop_count: got %0d expected 1", pops.size()); end
    checks++; if (tx_mis != 0) begin errors++; $display("FAIL txen_tx_wave: got %0d bad cycles expected 0", tx_mis); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL txen_done: got %0d expected 1", done_cnt); end
    checks++; if (cap_busy[cap_n - 1] !== 1'b0) begin errors++; $display("FAIL txen_busy: got %b expected 0", cap_busy[cap_n - 1]); end
    e = exp_q.pop_front();
    checks++; if (dec_q.size() != 1 || dec_q[0][8:1] !== e) begin errors++; $display("FAIL txen_frame: got %0h expected %0h", (dec_q.size() > 0) ? dec_q[0][8:1] : 8'hxx, e); end
    @(posedge clk); #1;
    tx_en = 1'b1;
    capture(2 * (NB * P + 1) + 6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL txen_resume_timeout: got no pop expected one"); end
    analyze();
    checks++; if (pops.size() != 2 || tx_mis != 0) begin errors++; $display("FAIL txen_resume: got %0d pops %0d bad cycles expected 2 and 0", pops.size(), tx_mis); end
    for (int j = 0; j < 2; j++) begin
      e = exp_q.pop_front();
      checks++; if (dec_q.size() <= j || dec_q[j][8:1] !== e) begin errors++; $display("FAIL txen_resume_frame%0d: got %0h expected %0h", j, (dec_q.size() > j) ? dec_q[j][8:1] : 8'hxx, e); end
    end
  endtask

  task automatic test_slow_tick();
    bit ok;
    logic [7:0] e;
    int first_low, ones;
    @(posedge clk); #1;
    tick_div = 4;
    repeat (8) @(posedge clk);
    #1;
    push_word(8'h80);
    capture(NB * 4 * P + 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL slow_pop_timeout: got no pop expected one"); end
    analyze();
    checks++; if (tx_mis != 0 || done_mis != 0) begin errors++; $display("FAIL slow_wave: got %0d bad tx %0d bad done expected 0", tx_mis, done_mis); end
    e = exp_q.pop_front();
    checks++; if (dec_q.size() != 1 || dec_q[0][8:1] !== e || dec_q[0][8] !== 1'b1) begin errors++; $display("FAIL slow_frame: got %0h expected %0h", (dec_q.size() > 0) ? dec_q[0][8:1] : 8'hxx, e); end
    // MSB, optional parity (=1 for 0x80) and stop: 64 high clks each
    first_low = -1; ones = 0;
    for (int c = 1; c < cap_n; c++) if (first_low < 0 && cap_tx[c] == 1'b0) first_low = c;
    if (first_low > 0 && done_idx > first_low)
      for (int c = first_low; c <= done_idx; c++) ones += int'(cap_tx[c]);
    checks++; if (ones != (2 + PAR) * 4 * P) begin errors++; $display("FAIL slow_high_run: got %0d clks expected %0d", ones, (2 + PAR) * 4 * P); end
    @(posedge clk); #1;
    tick_div = 1;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit ok;
    logic [7:0] e;
    @(posedge clk); #1;
    push_word(8'hA5);
    push_word(8'h07);
    capture(2 * (NB * P + 1) + 6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL parity_pop_timeout: got no pop expected one"); end
    analyze();
    checks++; if (pops.size() != 2 || tx_mis != 0) begin errors++; $display("FAIL parity_wave: got %0d pops %0d bad cycles expected 2 and 0", pops.size(), tx_mis); end
    checks++; if (done_idx != 11 * P + 1) begin errors++; $display("FAIL parity_frame_len: got %0d expected %0d", done_idx, 11 * P + 1); end
    checks++; if (dec_q.size() != 2 || dec_q[0][10:9] !== 2'b10) begin errors++; $display("FAIL parity_a5: got stop,parity %b expected 10", (dec_q.size() > 0) ? dec_q[0][10:9] : 2'bx); end
    checks++; if (dec_q.size() != 2 || dec_q[1][10:9] !== 2'b11) begin errors++; $display("FAIL parity_07: got stop,parity %b expected 11", (dec_q.size() > 1) ? dec_q[1][10:9] : 2'bx); end
    for (int j = 0; j < 2; j++) begin
      e = exp_q.pop_front();
      checks++; if (dec_q.size() <= j || dec_q[j][8:1] !== e) begin errors++; $display("FAIL parity_data%0d: got %0h expected %0h", j, (dec_q.size() > j) ? dec_q[j][8:1] : 8'hxx, e); end
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    bit ok;
    int bad;
    logic [7:0] e;
    @(posedge clk); #1;
    push_word(8'h3C);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fifo_rd) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_pop_timeout: got no pop expected one"); end
    e = exp_q.pop_front();
    repeat (40) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) begin errors++; $display("FAIL rstmid_abort (word %0h): got tx=%b busy=%b fifo_rd=%b expected 1 0 0", e, tx, busy, fifo_rd); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_idle: got %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    rst        = 1'b1;
    tick       = 1'b0;
    tx_en      = 1'b0;
    fifo_mpty  = 1'b1;
    fifo_rdata = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_txen_drop();
    test_slow_tick();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d words left expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx
